output_channel_tx: RTL and testbench
====================================

Name: output_channel_tx

Overview:
Transmit end of the router-to-router link. Takes 64-bit packets from the router crossbar, holds them in a small FIFO, and drives each packet onto the link to the next router's input channel buffer. Transfer uses a send/ready handshake: so is a one-cycle strobe with dout valid; ri is high when the downstream buffer can accept a packet. Sits at each router output port, paired with the downstream input channel buffer.

Parameters:
DEPTH, 2, FIFO entries; power of 2, minimum 2.
AW, 1, pointer width; must equal log2(DEPTH).

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
di  input  64  packet from crossbar.
we  input  1  write strobe from crossbar; one packet per cycle.
full  output  1  FIFO full; crossbar must not write while high.
so  output  1  send strobe to downstream; registered; high for exactly one cycle per packet.
dout  output  64  packet to downstream; registered; valid when so=1, holds last value otherwise.
ri  input  1  downstream ready (downstream buffer not full); sampled at posedge.
empty  output  1  FIFO empty.
ovf  output  1  sticky overflow error; write attempted while full.

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0, so=0, dout=64'b0, ovf=0; empty=1, full=0 immediately.
- full = (count==DEPTH); empty = (count==0). Both are decoded from registers, with no combinational path from we or ri.
- Write accept: at posedge, if we && !full, then mem[wr_ptr]<=di, wr_ptr++ (wraps modulo DEPTH).
- Write while full: data dropped, pointers unchanged, ovf<=1. ovf clears only on reset.
- A pop that happens at the same edge does not free a slot for that edge's write. Accept is decided on full before the edge.
- Pop: at posedge, if !empty && ri, then dout<=mem[rd_ptr], so<=1, rd_ptr++ (wraps).
- Otherwise so<=0 and dout holds its value.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- count: +1 on write only, -1 on pop only.
- Latency: packet written at edge N becomes FIFO head after N. Earliest so=1 is in the cycle after edge N+1, provided ri=1 at N+1 and the packet is at the head.
- Back-to-back: with ri held high and the FIFO non-empty, so stays high on consecutive cycles with a new dout each cycle. Throughput is 1 packet/cycle.
- ri low: no pop; so=0 next cycle; FIFO contents retained. If the FIFO fills, full rises.
- Order: strict FIFO; packets leave in write order, none lost or duplicated except on overflow.
- Reset mid-transfer: all queued packets discarded. so drops asynchronously with reset.

Optional Feature:
OUTPUT_CHANNEL_BYPASS_EN
- Defined: at a posedge where empty=1, we=1 and ri=1, di goes straight to dout with so<=1, and is not stored in the FIFO (count stays 0). Write-to-so latency is 1 edge. full and ovf are unaffected.
- Undefined: no bypass; every packet passes through the FIFO with the 2-edge minimum latency above.

Test Plan:
1. Reset check: assert reset mid-cycle with 2 entries queued -> immediately so=0, dout=0, empty=1, full=0, ovf=0. After release, no so pulse without new writes.
2. Single packet: ri=1, write 64'hDEAD_BEEF_0000_0001 at edge 1 -> so=1 with dout=64'hDEAD_BEEF_0000_0001 after edge 2 only; so=0 after edge 3. With BYPASS_EN: so=1 after edge 1.
3. Backpressure: ri=0, write 64'h1 then 64'h2 -> full=1, so stays 0. Raise ri -> so high for 2 consecutive cycles with dout 64'h1 then 64'h2; then empty=1.
4. Overflow: ri=0, write 64'hA, 64'hB, 64'hC -> 64'hC dropped, ovf=1 and stays 1. After ri=1, only 64'hA and 64'hB are sent.
5. Streaming with wrap: ri=1, we=1 for 10 cycles with di=64'h0..64'h9 -> so high for 10 consecutive cycles, dout 0..9 in order. full never asserts and ovf=0.
6. Simultaneous push/pop at full: DEPTH=2 full, ri=1, we=1 with di=64'hF -> pop occurs, 64'hF rejected, ovf=1, count goes to 1.

Source files
------------

// File: rtl/output_channel_tx_if.sv
// rtl/output_channel_tx_if.sv - crossbar-side and link-side signals of the output channel transmitter
// slave is the transmitter itself; master is whatever drives it (crossbar plus downstream ready).
interface output_channel_tx_if;
   logic [63:0] di;
   logic        we;
   logic        full;
   logic        so;
   logic [63:0] dout;
   logic        ri;
   logic        empty;
   logic        ovf;

   modport slave (
      input  di, we, ri,
      output full, so, dout, empty, ovf
   );

   modport master (
      output di, we, ri,
      input  full, so, dout, empty, ovf
   );
endinterface

// File: rtl/output_channel_tx.sv
// rtl/output_channel_tx.sv - router output port: packet FIFO driving a send/ready link
// Optional OUTPUT_CHANNEL_BYPASS_EN: an empty FIFO forwards a write straight to dout when ri is high.
module output_channel_tx #(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   output_channel_tx_if.slave bus
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          so_q, so_d;
   logic [63:0]   dout_q, dout_d;
   logic          ovf_q, ovf_d;
   logic          full, empty, wr_en, pop, byp;

   // Status comes only from registered count, never from we or ri.
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      ovf_d    = ovf_q;
      so_d     = 1'b0;
      byp      = 1'b0;
`ifdef OUTPUT_CHANNEL_BYPASS_EN
      byp      = empty && bus.we && bus.ri;
`else
      byp      = 1'b0;
`endif
      // Accept uses full before the edge, so a same-edge pop never frees room.
      wr_en    = bus.we && !full && !byp;
      pop      = !empty && bus.ri;

      if (bus.we && full)
         ovf_d = 1'b1;
      if (wr_en)
         wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         dout_d   = mem_q[rd_ptr_q];
         so_d     = 1'b1;
      end else if (byp) begin
         dout_d   = bus.di;
         so_d     = 1'b1;
      end

      case ({wr_en, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         so_q     <= 1'b0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         so_q     <= so_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= bus.di;
   end

   assign bus.full  = full;
   assign bus.empty = empty;
   assign bus.so    = so_q;
   assign bus.dout  = dout_q;
   assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_output_channel_tx.sv
// tb/tb_output_channel_tx.sv - directed bench for output_channel_tx with a packet scoreboard
// Packets expected on the link are queued when written and checked as so pulses appear.
module tb_output_channel_tx;
   logic clk = 1'b0;
   logic reset_i;
   int   total = 0;
   int   bad = 0;
   int   so_cnt = 0;
   int   full_seen;
   int   so_before;
   logic [63:0] sbq [$];

   output_channel_tx_if bus ();

   output_channel_tx #(.DEPTH(2), .AW(1)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every so pulse must match the oldest outstanding packet.
   always @(negedge clk) begin
      if (reset_i === 1'b0 && bus.so === 1'b1) begin
         so_cnt++;
         if (sbq.size() == 0)
            chk("so_spurious", {63'b0, bus.so}, 64'h0);
         else
            chk("dout_order", bus.dout, sbq.pop_front());
      end
   end

   task automatic wr(input logic [63:0] d, input bit accepted);
      @(negedge clk);
      bus.we = 1'b1;
      bus.di = d;
      if (accepted) sbq.push_back(d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.we = 1'b0;
      end
   endtask

   initial begin
      reset_i = 1'b1;
      bus.we  = 1'b0;
      bus.di  = '0;
      bus.ri  = 1'b0;
      #2;
      chk("rst_empty", {63'b0, bus.empty}, 64'h1);
      chk("rst_full",  {63'b0, bus.full},  64'h0);
      chk("rst_so",    {63'b0, bus.so},    64'h0);
      chk("rst_dout",  bus.dout,           64'h0);
      chk("rst_ovf",   {63'b0, bus.ovf},   64'h0);
      @(negedge clk);
      reset_i = 1'b0;

      // Single packet: so only after the second edge.
      bus.ri = 1'b1;
      wr(64'hDEAD_BEEF_0000_0001, 1'b1);
      idle(1);
      chk("single_so_edge1", {63'b0, bus.so}, 64'h0);
      idle(1);
      chk("single_so_edge2", {63'b0, bus.so}, 64'h1);
      chk("single_dout", bus.dout, 64'hDEAD_BEEF_0000_0001);
      idle(1);
      chk("single_so_edge3", {63'b0, bus.so}, 64'h0);

      // Backpressure fills the FIFO, then drains back to back.
      bus.ri = 1'b0;
      wr(64'h1, 1'b1);
      wr(64'h2, 1'b1);
      idle(1);
      chk("bp_full", {63'b0, bus.full}, 64'h1);
      chk("bp_so",   {63'b0, bus.so},   64'h0);
      bus.ri = 1'b1;
      idle(1);
      chk("bp_so1", {63'b0, bus.so}, 64'h1);
      chk("bp_d1",  bus.dout, 64'h1);
      idle(1);
      chk("bp_so2", {63'b0, bus.so}, 64'h1);
      chk("bp_d2",  bus.dout, 64'h2);
      chk("bp_empty", {63'b0, bus.empty}, 64'h1);
      idle(1);

      // Streaming through pointer wrap at one packet per cycle.
      full_seen = 0;
      so_before = so_cnt;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i >= 2) chk($sformatf("stream_so_%0d", i), {63'b0, bus.so}, 64'h1);
         if (bus.full === 1'b1) full_seen++;
         if (i < 10) begin
            bus.we = 1'b1;
            bus.di = 64'(i);
            sbq.push_back(64'(i));
         end else begin
            bus.we = 1'b0;
         end
      end
      idle(1);
      chk("stream_so_off", {63'b0, bus.so}, 64'h0);
      chk("stream_full_never", 64'(full_seen), 64'h0);
      chk("stream_count", 64'(so_cnt - so_before), 64'd10);
      chk("stream_ovf", {63'b0, bus.ovf}, 64'h0);

      // Write at full with a simultaneous pop is still rejected.
      bus.ri = 1'b0;
      wr(64'hE0, 1'b1);
      wr(64'hE1, 1'b1);
      idle(1);
      chk("pp_full", {63'b0, bus.full}, 64'h1);
      @(negedge clk);
      bus.ri = 1'b1;
      bus.we = 1'b1;
      bus.di = 64'hF;
      @(negedge clk);
      bus.we = 1'b0;
      bus.ri = 1'b0;
      chk("pp_so",    {63'b0, bus.so},    64'h1);
      chk("pp_ovf",   {63'b0, bus.ovf},   64'h1);
      chk("pp_full1", {63'b0, bus.full},  64'h0);
      chk("pp_empty", {63'b0, bus.empty}, 64'h0);
      bus.ri = 1'b1;
      idle(3);

      // Overflow drops the third packet; ovf is sticky.
      bus.ri = 1'b0;
      wr(64'hA, 1'b1);
      wr(64'hB, 1'b1);
      wr(64'hC, 1'b0);
      idle(1);
      chk("ovf_flag", {63'b0, bus.ovf},  64'h1);
      chk("ovf_full", {63'b0, bus.full}, 64'h1);
      so_before = so_cnt;
      bus.ri = 1'b1;
      idle(4);
      chk("ovf_sent", 64'(so_cnt - so_before), 64'd2);
      chk("ovf_empty", {63'b0, bus.empty}, 64'h1);
      chk("ovf_sticky", {63'b0, bus.ovf}, 64'h1);

      // Reset mid-cycle while so is high and a packet remains queued.
      bus.ri = 1'b0;
      wr(64'h51, 1'b1);
      wr(64'h52, 1'b1);
      @(negedge clk);
      bus.we = 1'b0;
      bus.ri = 1'b1;
      @(negedge clk);
      #2;
      reset_i = 1'b1;
      #1;
      chk("mid_so",    {63'b0, bus.so},    64'h0);
      chk("mid_dout",  bus.dout,           64'h0);
      chk("mid_empty", {63'b0, bus.empty}, 64'h1);
      chk("mid_full",  {63'b0, bus.full},  64'h0);
      chk("mid_ovf",   {63'b0, bus.ovf},   64'h0);
      sbq.delete();
      @(negedge clk);
      reset_i = 1'b0;
      so_before = so_cnt;
      idle(4);
      chk("post_rst_quiet", 64'(so_cnt - so_before), 64'd0);
      chk("sb_drained", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
